// File: rtl/cla_16_bit_pkg.sv
// Shared definitions for the 16-bit two-level carry-lookahead adder:
// widths, per-bit propagate/generate vector types and their helper.
package cla_16_bit_pkg;

  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;

  typedef logic [GROUP-1:0] grp_vec_t;

  // Per-bit propagate and generate for one lookahead group.
  typedef struct packed {
    grp_vec_t p;
    grp_vec_t g;
  } grp_pg_t;

  // Propagate is XOR-based so that p and g are mutually exclusive per bit;
  // this is what guarantees BP and BG can never both be high.
  function automatic grp_pg_t group_pg(input grp_vec_t a, input grp_vec_t b);
    grp_pg_t pg;
    pg.p = a ^ b;
    pg.g = a & b;
    return pg;
  endfunction

endpackage

// File: rtl/cla_4_bit.sv
// 4-bit lookahead group: produces its sum bits and the group propagate /
// generate pair. No carry-out; the carry into the next group comes from the
// second-level lookahead in the parent.
module cla_4_bit
  import cla_16_bit_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] s,
  output logic             GP,
  output logic             GG
);

  grp_pg_t  pg;
  grp_vec_t p;
  grp_vec_t g;
  grp_vec_t c;

  assign pg = group_pg(a, b);
  assign p  = pg.p;
  assign g  = pg.g;

  // Internal carries fully expanded so every bit sees at most one AND-OR level.
  always_comb begin
    c    = '0;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
  end

  // Group propagate / generate for the second lookahead level.
  always_comb begin
    GP = &p;
    GG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
  end

  assign s = p ^ c;

endmodule

// File: rtl/cla_16_bit.sv
// Registered 16-bit two-level carry-lookahead adder. Four 4-bit groups feed a
// lookahead unit that forms the group carry-ins, block propagate/generate and
// carry-out; all results are registered on a single clock.
module cla_16_bit
  import cla_16_bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             BP,
  output logic             BG
);

  logic [NGROUPS-1:0] gp;
  logic [NGROUPS-1:0] gg;
  logic [NGROUPS-1:0] c_grp;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_out_d, c_out_q;
  logic             bp_d, bp_q;
  logic             bg_d, bg_q;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
    cla_4_bit u_grp (
      .a    (a[k*GROUP +: GROUP]),
      .b    (b[k*GROUP +: GROUP]),
      .c_in (c_grp[k]),
      .s    (s_d[k*GROUP +: GROUP]),
      .GP   (gp[k]),
      .GG   (gg[k])
    );
  end

  // Second-level lookahead: group carry-ins expanded directly from c_in,
  // so no carry ever ripples from one group to the next.
  always_comb begin
    c_grp    = '0;
    c_grp[0] = c_in;
    c_grp[1] = gg[0] | (gp[0] & c_in);
    c_grp[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    c_grp[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
             | (gp[2] & gp[1] & gp[0] & c_in);
  end

  // Block propagate / generate for cascading; BG deliberately ignores c_in.
  always_comb begin
    bp_d    = &gp;
    bg_d    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0]);
    c_out_d = bg_d | (bp_d & c_in);
  end

  // Output registers; reset wins over the sampled inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
      bp_q    <= 1'b0;
      bg_q    <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
      bp_q    <= bp_d;
      bg_q    <= bg_d;
    end
  end

  assign s     = s_q;
  assign c_out = c_out_q;
  assign BP    = bp_q;
  assign BG    = bg_q;

endmodule

// File: tb/tb_cla_16_bit.sv
// Self-checking bench for cla_16_bit: reset, directed vector table,
// mid-cycle input change, and a back-to-back random stream with a mid-stream reset.
module tb_cla_16_bit;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic [15:0] s;
  logic        c_out;
  logic        BP;
  logic        BG;

  int checks;
  int errors;

  cla_16_bit dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .s     (s),
    .c_out (c_out),
    .BP    (BP),
    .BG    (BG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic [15:0] exp_s;
    logic        exp_c;
    logic        exp_bp;
    logic        exp_bg;
  } vec_t;

  vec_t vecs[12];

  task automatic check_out(input string name, input logic [15:0] es,
                           input logic ec, input logic ebp, input logic ebg);
    checks++;
    if (s !== es) begin
      errors++;
      $display("FAIL %s s: got %0d expected %0d", name, s, es);
    end
    checks++;
    if (c_out !== ec) begin
      errors++;
      $display("FAIL %s c_out: got %b expected %b", name, c_out, ec);
    end
    checks++;
    if (BP !== ebp) begin
      errors++;
      $display("FAIL %s BP: got %b expected %b", name, BP, ebp);
    end
    checks++;
    if (BG !== ebg) begin
      errors++;
      $display("FAIL %s BG: got %b expected %b", name, BG, ebg);
    end
  endtask

  // Reference model built from plain 17-bit arithmetic.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                       output logic [15:0] es, output logic ec,
                       output logic ebp, output logic ebg);
    logic [16:0] sum;
    logic [16:0] sum_nc;
    sum    = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
    sum_nc = {1'b0, ma} + {1'b0, mb};
    es  = sum[15:0];
    ec  = sum[16];
    ebp = ((ma ^ mb) == 16'hFFFF);
    ebg = sum_nc[16];
  endtask

  initial begin
    logic [15:0] ps;
    logic        pc, pbp, pbg;
    logic [15:0] ra, rb;
    logic        rc;
    logic        r_rst;

    checks = 0;
    errors = 0;

    vecs[0]  = '{"add_1060_11000",  16'd1060,  16'd11000, 1'b0, 16'd12060, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"add_12500_3100",  16'd12500, 16'd3100,  1'b1, 16'd15601, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"add_30143_2200",  16'd30143, 16'd2200,  1'b0, 16'd32343, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"ovf_65505_31",    16'd65505, 16'd31,    1'b0, 16'd0,     1'b1, 1'b0, 1'b1};
    vecs[4]  = '{"ovf_32005_33533", 16'd32005, 16'd33533, 1'b0, 16'd2,     1'b1, 1'b0, 1'b1};
    vecs[5]  = '{"all_ones_cin1",   16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1, 1'b0, 1'b1};
    vecs[6]  = '{"full_prop_cin1",  16'hFFFF,  16'h0000,  1'b1, 16'h0000,  1'b1, 1'b1, 1'b0};
    vecs[7]  = '{"full_prop_cin0",  16'hFFFF,  16'h0000,  1'b0, 16'hFFFF,  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"alt_prop_cin1",   16'h5555,  16'hAAAA,  1'b1, 16'h0000,  1'b1, 1'b1, 1'b0};
    vecs[9]  = '{"zero_cin1",       16'h0000,  16'h0000,  1'b1, 16'h0001,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{"msb_gen",         16'h8000,  16'h8000,  1'b0, 16'h0000,  1'b1, 1'b0, 1'b1};
    vecs[11] = '{"grp_boundary",    16'h0FFF,  16'h0001,  1'b0, 16'h1000,  1'b0, 1'b0, 1'b0};

    // Reset held two cycles with all-ones inputs.
    rst  = 1'b1;
    a    = 16'hFFFF;
    b    = 16'hFFFF;
    c_in = 1'b1;
    @(negedge clk);
    check_out("reset_cycle1", 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_out("reset_cycle2", 16'd0, 1'b0, 1'b0, 1'b0);

    // First result appears on the first edge after reset release.
    rst = 1'b0;
    a = vecs[0].a; b = vecs[0].b; c_in = vecs[0].c_in;
    @(negedge clk);
    check_out("first_after_reset", vecs[0].exp_s, vecs[0].exp_c, vecs[0].exp_bp, vecs[0].exp_bg);

    // Directed table, each checked one cycle after being applied.
    for (int i = 0; i < 12; i++) begin
      a = vecs[i].a; b = vecs[i].b; c_in = vecs[i].c_in;
      @(negedge clk);
      check_out(vecs[i].name, vecs[i].exp_s, vecs[i].exp_c, vecs[i].exp_bp, vecs[i].exp_bg);
    end

    // Inputs changed just after an edge must not disturb the registered result.
    a = 16'hFFFF; b = 16'h0000; c_in = 1'b1;
    @(posedge clk);
    #1;
    a = 16'd100; b = 16'd23; c_in = 1'b0;
    @(negedge clk);
    check_out("midcycle_hold", 16'h0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_out("midcycle_next", 16'd123, 1'b0, 1'b0, 1'b0);

    // Back-to-back random stream with one reset in the middle.
    ps = 16'd123; pc = 1'b0; pbp = 1'b0; pbg = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      ra    = 16'($urandom);
      rb    = 16'($urandom);
      rc    = 1'($urandom);
      r_rst = (i == 5000);
      a = ra; b = rb; c_in = rc; rst = r_rst;
      @(negedge clk);
      if (r_rst) begin
        ps = 16'd0; pc = 1'b0; pbp = 1'b0; pbg = 1'b0;
        check_out("midstream_reset", ps, pc, pbp, pbg);
      end else begin
        model(ra, rb, rc, ps, pc, pbp, pbg);
        check_out("random", ps, pc, pbp, pbg);
      end
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
